// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, boot/interrupt vectoring and
// assembly of 1- and 2-byte instructions for the IF/ID register.
module fetch_unit #(
  parameter logic [3:0] TWO_BYTE_OP = 4'hC,
  parameter logic [7:0] INT_OP      = 8'h78,
  parameter logic [7:0] RESET_VEC   = 8'h00,
  parameter logic [7:0] INT_VEC     = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] imem_rdata,
  output logic [7:0] imem_addr,
  input  logic       stall_F,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       intr,
  output logic [7:0] instr_F,
  output logic [7:0] imm_F,
  output logic [7:0] pc_F,
  output logic [7:0] pc_plus_1_F,
  output logic       valid_F
);

  typedef enum logic [1:0] {
    S_BOOT, S_FETCH, S_IMM, S_INTV
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] op_q, op_d;
  logic [7:0] op_pc_q, op_pc_d;
  logic       pend_q, pend_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] pcf_q, pcf_d;
  logic [7:0] pc1_q, pc1_d;
  logic       valid_q, valid_d;
  logic [7:0] pc_inc;

  assign pc_inc      = pc_q + 8'd1;
  assign instr_F     = instr_q;
  assign imm_F       = imm_q;
  assign pc_F        = pcf_q;
  assign pc_plus_1_F = pc1_q;
  assign valid_F     = valid_q;

  always_comb begin
    unique case (state_q)
      S_BOOT:  imem_addr = RESET_VEC;
      S_INTV:  imem_addr = INT_VEC;
      default: imem_addr = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    op_pc_d = op_pc_q;
    pend_d  = pend_q | intr;
    instr_d = instr_q;
    imm_d   = imm_q;
    pcf_d   = pcf_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (branch_taken && state_q != S_BOOT) begin
      pc_d    = branch_target;
      state_d = S_FETCH;
      valid_d = 1'b0;
    end else if (!stall_F) begin
      unique case (state_q)
        S_BOOT, S_INTV: begin
          pc_d    = imem_rdata;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (pend_q) begin
            // Fetch at PC is replayed after the ISR returns to pc_plus_1_F
            instr_d = INT_OP;
            imm_d   = 8'h00;
            pcf_d   = pc_q;
            pc1_d   = pc_q;
            valid_d = 1'b1;
            pend_d  = 1'b0;
            state_d = S_INTV;
          end else if (imem_rdata[7:4] == TWO_BYTE_OP) begin
            op_d    = imem_rdata;
            op_pc_d = pc_q;
            pc_d    = pc_inc;
            valid_d = 1'b0;
            state_d = S_IMM;
          end else begin
            instr_d = imem_rdata;
            imm_d   = 8'h00;
            pcf_d   = pc_q;
            pc1_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end
        S_IMM: begin
          instr_d = op_q;
          imm_d   = imem_rdata;
          pcf_d   = op_pc_q;
          pc1_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      pc_q    <= 8'h00;
      op_q    <= 8'h00;
      op_pc_q <= 8'h00;
      pend_q  <= 1'b0;
      instr_q <= 8'h00;
      imm_q   <= 8'h00;
      pcf_q   <= 8'h00;
      pc1_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      op_pc_q <= op_pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      pcf_q   <= pcf_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, 2-byte, stall,
// branch, interrupt, PC wrap and async reset mid-INTV.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] imem_rdata;
  logic [7:0] imem_addr;
  logic       stall_F = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       intr = 1'b0;
  logic [7:0] instr_F, imm_F, pc_F, pc_plus_1_F;
  logic       valid_F;

  logic [7:0] mem [256];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .imem_rdata(imem_rdata),
    .imem_addr(imem_addr),
    .stall_F(stall_F),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .intr(intr),
    .instr_F(instr_F),
    .imm_F(imm_F),
    .pc_F(pc_F),
    .pc_plus_1_F(pc_plus_1_F),
    .valid_F(valid_F)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [39:0] obs,
                     input logic [39:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic [7:0] i,
                     input logic [7:0] m, input logic [7:0] p,
                     input logic [7:0] p1, input logic v);
    chk(tag, {7'd0, instr_F, imm_F, pc_F, pc_plus_1_F, valid_F},
        {7'd0, i, m, p, p1, v});
  endtask

  task automatic addr(input string tag, input logic [7:0] a);
    chk(tag, {32'd0, imem_addr}, {32'd0, a});
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'hFF;
    mem[8'h10] = 8'h20; mem[8'h11] = 8'hC4;
    mem[8'h12] = 8'h55; mem[8'h13] = 8'h21;
    mem[8'h14] = 8'h22; mem[8'h15] = 8'hC5;
    mem[8'h16] = 8'h66; mem[8'h40] = 8'h30;
    mem[8'h41] = 8'hC6; mem[8'h42] = 8'h77;
    mem[8'h43] = 8'h31; mem[8'hFF] = 8'h32;

    step(); step();
    out("reset_out", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    addr("reset_addr", 8'h00);
    reset = 1'b1;

    step();
    out("boot", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    addr("boot_addr", 8'h10);
    step();
    out("first", 8'h20, 8'h00, 8'h10, 8'h11, 1'b1);
    step();
    out("op2_bubble", 8'h20, 8'h00, 8'h10, 8'h11, 1'b0);
    step();
    out("op2", 8'hC4, 8'h55, 8'h11, 8'h13, 1'b1);
    step();
    out("after2", 8'h21, 8'h00, 8'h13, 8'h14, 1'b1);

    stall_F = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      out("stall_out", 8'h21, 8'h00, 8'h13, 8'h14, 1'b1);
      addr("stall_addr", 8'h14);
    end
    stall_F = 1'b0;
    step();
    out("resume", 8'h22, 8'h00, 8'h14, 8'h15, 1'b1);

    step();
    out("br_op", 8'h22, 8'h00, 8'h14, 8'h15, 1'b0);
    branch_taken = 1'b1;
    branch_target = 8'h40;
    step();
    branch_taken = 1'b0;
    out("br_bubble", 8'h22, 8'h00, 8'h14, 8'h15, 1'b0);
    addr("br_addr", 8'h40);
    step();
    out("br_target", 8'h30, 8'h00, 8'h40, 8'h41, 1'b1);

    step();
    out("int_op2", 8'h30, 8'h00, 8'h40, 8'h41, 1'b0);
    intr = 1'b1;
    step();
    intr = 1'b0;
    out("int_done2", 8'hC6, 8'h77, 8'h41, 8'h43, 1'b1);
    step();
    out("int_op", 8'h78, 8'h00, 8'h43, 8'h43, 1'b1);
    addr("int_vec", 8'h01);
    step();
    out("isr_bubble", 8'h78, 8'h00, 8'h43, 8'h43, 1'b0);
    addr("isr_addr", 8'hFF);
    step();
    out("wrap", 8'h32, 8'h00, 8'hFF, 8'h00, 1'b1);
    addr("wrap_addr", 8'h00);
    step();
    out("at_zero", 8'h10, 8'h00, 8'h00, 8'h01, 1'b1);

    intr = 1'b1;
    step();
    intr = 1'b0;
    out("pre_int", 8'hFF, 8'h00, 8'h01, 8'h02, 1'b1);
    step();
    out("int2", 8'h78, 8'h00, 8'h02, 8'h02, 1'b1);
    addr("intv_addr", 8'h01);
    #2 reset = 1'b0;
    #1;
    out("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    addr("async_addr", 8'h00);
    step();
    reset = 1'b1;
    step();
    addr("reboot_addr", 8'h10);
    step();
    out("reboot", 8'h20, 8'h00, 8'h10, 8'h11, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
